// File: rtl/mov_exec.sv
// Small move-machine: executes a loaded program one instruction per cycle and
// streams "out" results through a bounded FIFO until the run completes.
module mov_exec #(
    parameter int MemoryElementWidth = 12,
    parameter int NLocal = 8,
    parameter int NCode = 16,
    parameter int NOut = 4,
    parameter int MaxSteps = 255,
    localparam int W = MemoryElementWidth,
    localparam int LA = $clog2(NLocal),
    localparam int CA = $clog2(NCode + 1),
    localparam int IW = 3 + LA + W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          loadEnable,
    input  logic [CA-1:0] loadAddr,
    input  logic [IW-1:0] loadData,
    input  logic [W-1:0]  inData,
    input  logic          inValid,
    output logic          inReady,
    output logic [W-1:0]  outData,
    output logic          outValid,
    input  logic          outReady,
    output logic          finished,
    output logic          success,
    output logic [15:0]   steps
);
    localparam int CI = (NCode > 1) ? $clog2(NCode) : 1;
    localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
    localparam int NW = $clog2(NOut + 1);
    localparam logic [CA-1:0] CODE_END   = CA'(NCode);
    localparam logic [LA:0]   LOCAL_END  = (LA + 1)'(NLocal);
    localparam logic [15:0]   STEP_LIMIT = 16'(MaxSteps);
    localparam logic [NW-1:0] FIFO_FULL  = NW'(NOut);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NOut - 1);

    localparam logic [2:0] OP_HALT = 3'd0, OP_MOVIMM = 3'd1, OP_MOVLOC = 3'd2;
    localparam logic [2:0] OP_OUT = 3'd3, OP_IN = 3'd4, OP_JUMP = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, DRAIN, DONE} state_t;

    // state_q is the FSM state; it is left as a named enum for hierarchical probing.
    state_t        state_q, state_d;
    logic [IW-1:0] code_mem  [NCode];
    logic [W-1:0]  local_mem [NLocal];
    logic [W-1:0]  fifo_mem  [NOut];
    logic [CA-1:0] ip_q, ip_d;
    logic [15:0]   steps_q;
    logic          success_q, success_d;
    logic [PW-1:0] head_q, tail_q;
    logic [NW-1:0] count_q;

    logic [IW-1:0] instr;
    logic [2:0]    opcode;
    logic [LA-1:0] target, src;
    logic [W-1:0]  operand, target_val, src_val, local_wdata;
    logic          target_ok, src_ok, fifo_full;
    logic          start, retire, push, pop, local_we, in_ready;

    assign instr      = code_mem[ip_q[CI-1:0]];
    assign opcode     = instr[IW-1:IW-3];
    assign target     = instr[IW-4:W];
    assign operand    = instr[W-1:0];
    assign src        = operand[LA-1:0];
    assign target_ok  = {1'b0, target} < LOCAL_END;
    assign src_ok     = {1'b0, src} < LOCAL_END;
    assign target_val = target_ok ? local_mem[target] : '0;
    assign src_val    = src_ok ? local_mem[src] : '0;
    assign fifo_full  = (count_q == FIFO_FULL);
    assign pop        = (count_q != '0) && outReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        success_d   = success_q;
        start       = 1'b0;
        retire      = 1'b0;
        push        = 1'b0;
        local_we    = 1'b0;
        local_wdata = '0;
        in_ready    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (run) begin
                    start   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ip_q >= CODE_END) begin
                    success_d = 1'b1;
                    state_d   = DRAIN;
                end else if (steps_q == STEP_LIMIT && opcode != OP_HALT) begin
                    success_d = 1'b0;
                    state_d   = DRAIN;
                end else begin
                    case (opcode)
                        OP_HALT: begin
                            retire    = 1'b1;
                            success_d = 1'b1;
                            state_d   = DRAIN;
                        end
                        OP_MOVIMM: begin
                            retire      = 1'b1;
                            local_we    = target_ok;
                            local_wdata = operand;
                            ip_d        = ip_q + 1'b1;
                        end
                        OP_MOVLOC: begin
                            retire      = 1'b1;
                            local_we    = target_ok;
                            local_wdata = src_val;
                            ip_d        = ip_q + 1'b1;
                        end
                        // Fullness is judged before this cycle's pop, so a full FIFO always stalls.
                        OP_OUT: begin
                            if (!fifo_full) begin
                                retire = 1'b1;
                                push   = 1'b1;
                                ip_d   = ip_q + 1'b1;
                            end
                        end
                        OP_IN: begin
                            in_ready = 1'b1;
                            if (inValid) begin
                                retire      = 1'b1;
                                local_we    = target_ok;
                                local_wdata = inData;
                                ip_d        = ip_q + 1'b1;
                            end
                        end
                        OP_JUMP: begin
                            retire = 1'b1;
                            ip_d   = operand[CA-1:0];
                            if (operand[CA-1:0] >= CODE_END) begin
                                success_d = 1'b1;
                                state_d   = DRAIN;
                            end
                        end
                        default: begin
                            success_d = 1'b0;
                            state_d   = DRAIN;
                        end
                    endcase
                end
            end
            DRAIN: begin
                if (count_q == '0 || (count_q == NW'(1) && pop)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ip_q      <= '0;
            steps_q   <= '0;
            success_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else if (start) begin
            ip_q      <= '0;
            steps_q   <= '0;
            success_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            ip_q      <= ip_d;
            success_q <= success_d;
            if (retire) steps_q <= steps_q + 16'd1;
            if (push) tail_q <= (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
            if (pop) head_q <= (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
            count_q <= count_q + NW'(push) - NW'(pop);
        end
    end

    // Storage arrays are deliberately unreset so programs and locals survive reset.
    always_ff @(posedge clock) begin
        if (loadEnable && (state_q == IDLE || state_q == DONE) && loadAddr < CODE_END)
            code_mem[loadAddr[CI-1:0]] <= loadData;
        if (local_we) local_mem[target] <= local_wdata;
        if (push) fifo_mem[tail_q] <= target_val;
    end

    assign inReady  = in_ready;
    assign outData  = fifo_mem[head_q];
    assign outValid = (count_q != '0);
    assign finished = (state_q == DONE);
    assign success  = success_q;
    assign steps    = steps_q;
endmodule

// File: tb/tb_mov_exec.sv
// Bench for mov_exec: directed scenarios plus random programs checked against an
// instruction-level interpreter of the machine.
module tb_mov_exec;
    localparam int W = 12;
    localparam int NLOCAL = 8;
    localparam int NCODE = 16;
    localparam int NOUT = 2;
    localparam int MAX_STEPS = 10;
    localparam int CA = 5;
    localparam int IW = 18;

    logic          clock = 1'b0;
    logic          reset, run, loadEnable;
    logic [CA-1:0] loadAddr;
    logic [IW-1:0] loadData;
    logic [W-1:0]  inData;
    logic          inValid, inReady;
    logic [W-1:0]  outData;
    logic          outValid, outReady, finished, success;
    logic [15:0]   steps;

    mov_exec #(.MemoryElementWidth(W), .NLocal(NLOCAL), .NCode(NCODE),
               .NOut(NOUT), .MaxSteps(MAX_STEPS)) dut (
        .clock(clock), .reset(reset), .run(run), .loadEnable(loadEnable),
        .loadAddr(loadAddr), .loadData(loadData), .inData(inData),
        .inValid(inValid), .inReady(inReady), .outData(outData),
        .outValid(outValid), .outReady(outReady), .finished(finished),
        .success(success), .steps(steps)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass = 0;

    logic [IW-1:0] code_m [NCODE];
    logic [W-1:0]  loc_m  [NLOCAL];
    logic [W-1:0]  in_vals [16];
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  got_q [$];
    logic          exp_ok;
    int            exp_steps;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int tgt, input int opd);
        return {op[2:0], tgt[2:0], opd[11:0]};
    endfunction

    // Interpreter of the program in code_m; updates loc_m and fills the expectations.
    function automatic void model_run();
        int ip, st, k;
        bit fin;
        logic [2:0] op, tgt;
        logic [11:0] opd;
        ip = 0; st = 0; k = 0; fin = 0;
        exp_q.delete();
        while (!fin) begin
            if (ip >= NCODE) begin
                exp_ok = 1'b1; fin = 1;
            end else begin
                op = code_m[ip][17:15];
                tgt = code_m[ip][14:12];
                opd = code_m[ip][11:0];
                if (st == MAX_STEPS && op != 3'd0) begin
                    exp_ok = 1'b0; fin = 1;
                end else begin
                    case (op)
                        3'd0: begin st++; exp_ok = 1'b1; fin = 1; end
                        3'd1: begin loc_m[tgt] = opd; st++; ip++; end
                        3'd2: begin loc_m[tgt] = loc_m[opd[2:0]]; st++; ip++; end
                        3'd3: begin exp_q.push_back(loc_m[tgt]); st++; ip++; end
                        3'd4: begin loc_m[tgt] = in_vals[k]; k++; st++; ip++; end
                        3'd5: begin
                            st++;
                            ip = int'(opd[4:0]);
                            if (ip >= NCODE) begin exp_ok = 1'b1; fin = 1; end
                        end
                        default: begin exp_ok = 1'b0; fin = 1; end
                    endcase
                end
            end
        end
        exp_steps = st;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_program();
        for (int a = 0; a < NCODE; a++) begin
            loadEnable = 1'b1; loadAddr = CA'(a); loadData = code_m[a];
            tick();
        end
        // Out-of-range writes must not alias onto address 0.
        loadAddr = 5'd16; loadData = mk(7, 0, 0); tick();
        loadAddr = 5'd31; tick();
        loadEnable = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int ready_pct, input int valid_pct);
        bit done;
        int in_idx;
        done = 0; in_idx = 0;
        got_q.delete();
        for (int c = 0; c < 600 && !done; c++) begin
            outReady = ($urandom_range(0, 99) < ready_pct);
            inValid = ($urandom_range(0, 99) < valid_pct);
            inData = in_vals[in_idx];
            @(negedge clock);
            if (finished) done = 1;
            else begin
                if (outValid && outReady) got_q.push_back(outData);
                if (inValid && inReady && in_idx < 15) in_idx++;
                tick();
            end
        end
        check_eq({tag, " finished"}, done, 1);
        check_eq({tag, " success"}, success, exp_ok);
        check_eq({tag, " steps"}, steps, exp_steps);
        check_eq({tag, " out_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s out[%0d]", tag, i), got_q[i], exp_q[i]);
        check_eq({tag, " out_valid_idle"}, outValid, 0);
    endtask

    task automatic fill_halt();
        for (int a = 0; a < NCODE; a++) code_m[a] = mk(0, 0, 0);
    endtask

    task automatic set_prog_basic();
        fill_halt();
        code_m[0] = mk(1, 0, 1); code_m[1] = mk(1, 1, 2); code_m[2] = mk(1, 2, 3);
        code_m[3] = mk(3, 0, 0); code_m[4] = mk(3, 1, 0); code_m[5] = mk(3, 2, 0);
    endtask

    task automatic directed(input string tag);
        load_program();
        model_run();
        start_run();
        finish_run(tag, 100, 100);
    endtask

    initial begin
        bit ok_flag;
        int r, op, tgt, opd;
        reset = 1'b1; run = 1'b0; loadEnable = 1'b0; loadAddr = '0; loadData = '0;
        inData = '0; inValid = 1'b0; outReady = 1'b0;
        for (int i = 0; i < 16; i++) in_vals[i] = W'($urandom_range(0, 4095));
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        check_eq("rst out_valid", outValid, 0);
        check_eq("rst in_ready", inReady, 0);
        check_eq("rst finished", finished, 0);
        check_eq("rst success", success, 0);
        check_eq("rst steps", steps, 0);

        // Give every local a defined value before anything reads it.
        fill_halt();
        for (int a = 0; a < NLOCAL; a++) code_m[a] = mk(1, a, int'($urandom_range(0, 4095)));
        directed("init");

        set_prog_basic();
        directed("basic");
        check_eq("basic steps7", steps, 7);

        // Backpressure: four outs into a two-deep FIFO with the consumer stalled.
        fill_halt();
        for (int a = 0; a < 4; a++) begin
            code_m[a] = mk(1, a, int'($urandom_range(0, 4095)));
            code_m[a + 4] = mk(3, a, 0);
        end
        load_program();
        model_run();
        outReady = 1'b0; inValid = 1'b0;
        start_run();
        repeat (12) tick();
        check_eq("bp steps_frozen", steps, 6);
        check_eq("bp out_valid", outValid, 1);
        check_eq("bp not_finished", finished, 0);
        finish_run("bp", 100, 100);

        // Input wait; a load attempted while stalled in EXEC must be ignored.
        fill_halt();
        code_m[0] = mk(4, 3, 0); code_m[1] = mk(3, 3, 0);
        in_vals[0] = 12'hABC;
        load_program();
        model_run();
        inValid = 1'b0; outReady = 1'b1;
        start_run();
        ok_flag = 1;
        loadEnable = 1'b1; loadAddr = 5'd1; loadData = mk(7, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (inReady !== 1'b1) ok_flag = 0;
            tick();
        end
        loadEnable = 1'b0;
        check_eq("in_wait ready_held", ok_flag, 1);
        finish_run("in_wait", 100, 100);

        fill_halt();
        code_m[0] = mk(1, 5, 11); code_m[1] = mk(1, 6, 22); code_m[2] = mk(7, 0, 0);
        directed("illegal");

        fill_halt();
        code_m[0] = mk(5, 0, 0);
        directed("step_limit");

        fill_halt();
        code_m[0] = mk(5, 0, 15); code_m[15] = mk(1, 7, 77);
        directed("ip_end");

        fill_halt();
        code_m[0] = mk(5, 0, 20);
        directed("jump_far");

        // Reset mid-run while output is pending, then rerun without reloading.
        set_prog_basic();
        load_program();
        model_run();
        outReady = 1'b0; inValid = 1'b0;
        start_run();
        ok_flag = 0;
        for (int c = 0; c < 20 && !ok_flag; c++) begin
            @(negedge clock);
            if (outValid) ok_flag = 1;
            tick();
        end
        check_eq("rst_mid saw_out_valid", ok_flag, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mid out_valid", outValid, 0);
        check_eq("rst_mid finished", finished, 0);
        check_eq("rst_mid steps", steps, 0);
        tick();
        reset = 1'b0;
        tick();
        model_run();
        start_run();
        finish_run("rerun", 100, 100);

        for (int p = 0; p < 40; p++) begin
            for (int a = 0; a < NCODE; a++) begin
                r = $urandom_range(0, 99);
                tgt = $urandom_range(0, 7);
                opd = $urandom_range(0, 4095);
                if (r < 8) op = 0;
                else if (r < 30) op = 1;
                else if (r < 45) op = 2;
                else if (r < 65) op = 3;
                else if (r < 80) op = 4;
                else if (r < 95) begin op = 5; opd = $urandom_range(0, 17); end
                else op = $urandom_range(6, 7);
                code_m[a] = mk(op, tgt, opd);
            end
            for (int i = 0; i < 16; i++) in_vals[i] = W'($urandom_range(0, 4095));
            load_program();
            model_run();
            start_run();
            finish_run($sformatf("rand%0d", p), $urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mov_exec.md
MOV_EXEC -- requirements
Module: mov_exec

Interface
REQ-001 Parameter MemoryElementWidth, default 12: data word width W.
REQ-002 Parameter NLocal, default 8 (>=2): local memory words; LA = $clog2(NLocal).
REQ-003 Parameter NCode, default 16: instruction memory words; CA = $clog2(NCode+1).
REQ-004 Parameter NOut, default 4 (>=1): output FIFO depth.
REQ-005 Parameter MaxSteps, default 255: step limit per run.
REQ-006 Instruction width IW = 3+LA+W; fields are opcode [IW-1:IW-3], target [IW-4:W], operand [W-1:0].
REQ-007 Ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  start request, level-sampled.
- loadEnable  in  1  write instruction memory.
- loadAddr  in  CA  instruction address.
- loadData  in  IW  instruction word.
- inData  in  W  input channel data.
- inValid  in  1  input data available.
- inReady  out  1  engine accepts inData.
- outData  out  W  FIFO head.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  consumer accepts outData.
- finished  out  1  run complete and FIFO drained.
- success  out  1  completion status, valid while finished=1.
- steps  out  16  instructions retired this run.

Function
REQ-008 States: IDLE, EXEC, DRAIN, DONE.
REQ-009 Instruction memory writes take effect only in IDLE or DONE; loadEnable is ignored in EXEC and DRAIN, and when loadAddr>=NCode.
REQ-010 run=1 in IDLE or DONE takes effect next edge: ip=0, steps=0, finished=0, success=0, FIFO emptied, state EXEC. run is ignored in EXEC and DRAIN.
REQ-011 EXEC executes code[ip] in one cycle unless it stalls; a retired instruction increments steps.
REQ-012 Opcodes:
- 0 halt: success=1, go to DRAIN.
- 1 movImm: local[target]=operand.
- 2 movLoc: local[target]=local[operand[LA-1:0]].
- 3 out: push local[target] into FIFO.
- 4 in: local[target]=inData.
- 5 jump: ip=operand[CA-1:0].
- 6, 7 illegal: success=0, go to DRAIN, no retire.
- All except jump and halt set ip=ip+1.
REQ-013 When ip reaches NCode, or jump targets >=NCode: success=1, go to DRAIN.
REQ-014 When steps equals MaxSteps and the current instruction is not halt: success=0, go to DRAIN.
REQ-015 out stalls while the FIFO is full at the start of the cycle, even if a pop occurs in the same cycle.
REQ-016 inReady=1 only in EXEC with opcode 4 at ip; the instruction retires on inValid&&inReady, otherwise it stalls.
REQ-017 FIFO: outValid=!empty, outData=head; pop on outValid&&outReady; push and pop in the same cycle are both honoured when not full; order is preserved.
REQ-018 Pops continue in DRAIN and DONE; DRAIN moves to DONE on the edge where the FIFO becomes, or is, empty; finished=1 in DONE only.
REQ-019 Index arithmetic is unsigned, with no wrap on ip; a movLoc source index >=NLocal reads 0; a target >=NLocal discards the write but still retires.
REQ-020 success and steps hold their values in DONE until the next run.

Reset
REQ-021 reset=1 forces state IDLE, ip=0, steps=0, finished=0, success=0, FIFO empty, outValid=0, inReady=0, asynchronously, including mid-run.
REQ-022 Instruction and local memories are not reset; contents are retained across reset.

Verification
REQ-023 Program movImm L0=1, L1=2, L2=3; out L0, L1, L2; halt, with outReady=1 -> outData 1,2,3 in order, finished=1, success=1, steps=7.
REQ-024 NOut=2, outReady=0, four outs -> steps freezes at the third out and outValid stays 1; outReady=1 -> all four values delivered in order, finished only after the last pop.
REQ-025 in L3 with inValid=0 for 5 cycles, then inValid=1 and inData=0xABC -> inReady=1 throughout the wait, and a following out L3 emits 0xABC.
REQ-026 Opcode 7 at ip=2 after two movImm -> finished=1, success=0, steps=2.
REQ-027 jump to 0 at ip=0 with MaxSteps=10 -> finished=1, success=0, steps=10.
REQ-028 reset asserted while outValid=1 in EXEC -> outValid=0 and finished=0 immediately; rerunning the REQ-023 program without reloading -> identical result.
